// File: rtl/parity_stream_gen.sv
// Purpose : one-stage register slice that generates (and optionally checks) per-lane parity
//           and produces a per-packet summary of parity, error status and beat count.
// Latency : 1 cycle from s_data to m_data/m_par/m_err; the packet summary is registered
//           on the edge that accepts the last beat, so pkt_valid lines up with that beat on m_*.
// Backpressure: s_ready = !m_valid || m_ready, so the slice runs at 1 beat/cycle with no bubble.
//           m_* hold while stalled. pkt_valid is a 1-cycle pulse and is never backpressured.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   s_valid/s_ready/s_data/s_last input beat stream
//   s_chk, s_par                  per-beat check enable and expected lane parity
//   m_valid/m_ready/m_data/m_last registered output beat stream
//   m_par, m_err                  generated lane parity and beat mismatch flag
//   pkt_valid, pkt_par, pkt_err,  packet summary, held until the next summary
//   pkt_beats
//   err_count                     saturating count of beat errors since reset
module parity_stream_gen #(
    parameter int DATA_WIDTH = 64,
    parameter int LANES      = 8,
    parameter int ODD_MODE   = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    input  logic                  s_chk,
    input  logic [LANES-1:0]      s_par,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic [LANES-1:0]      m_par,
    output logic                  m_err,
    output logic                  pkt_valid,
    output logic                  pkt_par,
    output logic                  pkt_err,
    output logic [15:0]           pkt_beats,
    output logic [15:0]           err_count
);

    localparam int   LW  = DATA_WIDTH / LANES;
    localparam logic ODD = (ODD_MODE != 0);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    state_t                  state_q, state_d;

    logic                    m_valid_q;
    logic [DATA_WIDTH-1:0]   m_data_q;
    logic                    m_last_q;
    logic [LANES-1:0]        m_par_q;
    logic                    m_err_q;
    logic                    pkt_valid_q;
    logic                    pkt_par_q;
    logic                    pkt_err_q;
    logic [15:0]             pkt_beats_q;
    logic [15:0]             err_count_q;
    logic                    par_acc_q;
    logic                    err_acc_q;
    logic [15:0]             beat_cnt_q;

    logic                    acc;
    logic                    first_beat;
    logic [LANES-1:0]        par_beat;
    logic                    err_beat;
    logic                    raw_par_beat;
    logic                    par_acc_d;
    logic                    err_acc_d;
    logic [15:0]             beat_cnt_d;

    assign s_ready = !m_valid_q || m_ready;
    assign acc     = s_valid && s_ready;

    // In IDLE no beat of the current packet has been taken yet, so the accumulators
    // are loaded from this beat instead of combined with stale values.
    assign first_beat = (state_q == IDLE);

    always_comb begin
        par_beat = '0;
        for (int i = 0; i < LANES; i++) begin
            par_beat[i] = (^s_data[i*LW +: LW]) ^ ODD;
        end
    end

    // Packet parity is tracked in raw (even) form; ODD is applied once at the summary.
    assign raw_par_beat = ^s_data;
    assign err_beat     = s_chk && (par_beat != s_par);

    assign par_acc_d  = first_beat ? raw_par_beat : (par_acc_q ^ raw_par_beat);
    assign err_acc_d  = first_beat ? err_beat     : (err_acc_q | err_beat);
    assign beat_cnt_d = first_beat ? 16'd1 :
                        ((beat_cnt_q == 16'hFFFF) ? beat_cnt_q : beat_cnt_q + 16'd1);

    always_comb begin
        state_d = state_q;
        if (acc) begin
            state_d = s_last ? IDLE : BUSY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q   <= 1'b0;
            m_data_q    <= '0;
            m_last_q    <= 1'b0;
            m_par_q     <= '0;
            m_err_q     <= 1'b0;
            pkt_valid_q <= 1'b0;
            pkt_par_q   <= 1'b0;
            pkt_err_q   <= 1'b0;
            pkt_beats_q <= '0;
            err_count_q <= '0;
            par_acc_q   <= 1'b0;
            err_acc_q   <= 1'b0;
            beat_cnt_q  <= '0;
        end else begin
            pkt_valid_q <= acc && s_last;
            if (acc) begin
                m_valid_q  <= 1'b1;
                m_data_q   <= s_data;
                m_last_q   <= s_last;
                m_par_q    <= par_beat;
                m_err_q    <= err_beat;
                par_acc_q  <= par_acc_d;
                err_acc_q  <= err_acc_d;
                beat_cnt_q <= beat_cnt_d;
                if (err_beat && (err_count_q != 16'hFFFF)) begin
                    err_count_q <= err_count_q + 16'd1;
                end
                if (s_last) begin
                    pkt_par_q   <= par_acc_d ^ ODD;
                    pkt_err_q   <= err_acc_d;
                    pkt_beats_q <= beat_cnt_d;
                end
            end else if (m_ready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign m_valid   = m_valid_q;
    assign m_data    = m_data_q;
    assign m_last    = m_last_q;
    assign m_par     = m_par_q;
    assign m_err     = m_err_q;
    assign pkt_valid = pkt_valid_q;
    assign pkt_par   = pkt_par_q;
    assign pkt_err   = pkt_err_q;
    assign pkt_beats = pkt_beats_q;
    assign err_count = err_count_q;

endmodule

// File: tb/tb_parity_stream_gen.sv
// Purpose : directed bench for parity_stream_gen, even-parity and odd-parity instances.
// Latency : inputs driven and outputs sampled on the falling edge; DUT registers on rising edge.
// Backpressure: m_ready driven per test on the even instance; the odd instance always ready.
module tb_parity_stream_gen;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        s_valid, s_ready, s_last, s_chk, m_valid, m_ready, m_last, m_err;
    logic [63:0] s_data, m_data;
    logic [7:0]  s_par, m_par;
    logic        pkt_valid, pkt_par, pkt_err;
    logic [15:0] pkt_beats, err_count;

    logic        o_s_valid, o_s_ready, o_s_last, o_m_valid, o_m_last, o_m_err;
    logic [63:0] o_s_data, o_m_data;
    logic [7:0]  o_m_par;
    logic        o_pkt_valid, o_pkt_par, o_pkt_err;
    logic [15:0] o_pkt_beats, o_err_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    parity_stream_gen #(.DATA_WIDTH(64), .LANES(8), .ODD_MODE(0)) u_even (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .s_chk(s_chk), .s_par(s_par),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
        .m_par(m_par), .m_err(m_err),
        .pkt_valid(pkt_valid), .pkt_par(pkt_par), .pkt_err(pkt_err),
        .pkt_beats(pkt_beats), .err_count(err_count)
    );

    parity_stream_gen #(.DATA_WIDTH(64), .LANES(8), .ODD_MODE(1)) u_odd (
        .clk(clk), .rst_n(rst_n),
        .s_valid(o_s_valid), .s_ready(o_s_ready), .s_data(o_s_data), .s_last(o_s_last),
        .s_chk(1'b0), .s_par(8'h00),
        .m_valid(o_m_valid), .m_ready(1'b1), .m_data(o_m_data), .m_last(o_m_last),
        .m_par(o_m_par), .m_err(o_m_err),
        .pkt_valid(o_pkt_valid), .pkt_par(o_pkt_par), .pkt_err(o_pkt_err),
        .pkt_beats(o_pkt_beats), .err_count(o_err_count)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [63:0] d, input logic last, input logic chk, input logic [7:0] par);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        s_chk   = chk;
        s_par   = par;
    endtask

    task automatic idle();
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        s_chk   = 1'b0;
        s_par   = '0;
    endtask

    task automatic check_all_zero(input string pfx);
        check_val({pfx, "_m_valid"},   m_valid,   0);
        check_val({pfx, "_m_data"},    m_data,    0);
        check_val({pfx, "_m_last"},    m_last,    0);
        check_val({pfx, "_m_par"},     m_par,     0);
        check_val({pfx, "_m_err"},     m_err,     0);
        check_val({pfx, "_pkt_valid"}, pkt_valid, 0);
        check_val({pfx, "_pkt_par"},   pkt_par,   0);
        check_val({pfx, "_pkt_err"},   pkt_err,   0);
        check_val({pfx, "_pkt_beats"}, pkt_beats, 0);
        check_val({pfx, "_err_count"}, err_count, 0);
        check_val({pfx, "_s_ready"},   s_ready,   1);
    endtask

    initial begin
        rst_n     = 1'b0;
        m_ready   = 1'b1;
        idle();
        o_s_valid = 1'b0;
        o_s_data  = '0;
        o_s_last  = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("por");
        rst_n = 1'b1;
        @(negedge clk);

        // Single-beat packet on even instance, all-zero beat on odd instance.
        drive(64'h0000_0000_0001_FFFF, 1'b1, 1'b0, 8'h00);
        o_s_valid = 1'b1;
        o_s_data  = 64'h0;
        o_s_last  = 1'b1;
        @(negedge clk);
        check_val("t2_m_valid",   m_valid,   1);
        check_val("t2_m_data",    m_data,    64'h0000_0000_0001_FFFF);
        check_val("t2_m_par",     m_par,     8'h04);
        check_val("t2_m_err",     m_err,     0);
        check_val("t2_pkt_valid", pkt_valid, 1);
        check_val("t2_pkt_par",   pkt_par,   1);
        check_val("t2_pkt_beats", pkt_beats, 1);
        check_val("t6_m_par",     o_m_par,   8'hFF);
        check_val("t6_pkt_par",   o_pkt_par, 1);
        check_val("t6_pkt_valid", o_pkt_valid, 1);
        idle();
        o_s_valid = 1'b0;
        @(negedge clk);
        check_val("t2_pkt_valid_pulse", pkt_valid, 0);
        check_val("t2_m_valid_drop",    m_valid,   0);
        check_val("t2_pkt_beats_hold",  pkt_beats, 1);

        // Checked beat with parity mismatch.
        drive(64'h0000_0000_AAAA_0555, 1'b1, 1'b1, 8'h01);
        @(negedge clk);
        check_val("t3_m_par",     m_par,     8'h00);
        check_val("t3_m_err",     m_err,     1);
        check_val("t3_pkt_err",   pkt_err,   1);
        check_val("t3_err_count", err_count, 1);
        idle();
        @(negedge clk);

        // Backpressure: 3-beat packet, m_ready low for 3 edges.
        m_ready = 1'b0;
        drive(64'h1, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        check_val("t4_b1_m_par", m_par, 8'h01);
        check_val("t4_b1_valid", m_valid, 1);
        drive(64'h3, 1'b0, 1'b0, 8'h00);
        check_val("t4_s_ready_stall0", s_ready, 0);
        @(negedge clk);
        check_val("t4_s_ready_stall1", s_ready, 0);
        check_val("t4_m_data_hold1",   m_data,  64'h1);
        @(negedge clk);
        check_val("t4_s_ready_stall2", s_ready, 0);
        check_val("t4_m_data_hold2",   m_data,  64'h1);
        check_val("t4_m_par_hold2",    m_par,   8'h01);
        m_ready = 1'b1;
        #1;
        check_val("t4_s_ready_release", s_ready, 1);
        @(negedge clk);
        check_val("t4_b2_m_data", m_data, 64'h3);
        check_val("t4_b2_m_par",  m_par,  8'h00);
        check_val("t4_b2_pkt_valid", pkt_valid, 0);
        drive(64'h7, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        check_val("t4_b3_m_data",    m_data,    64'h7);
        check_val("t4_b3_m_par",     m_par,     8'h01);
        check_val("t4_b3_m_last",    m_last,    1);
        check_val("t4_pkt_valid",    pkt_valid, 1);
        check_val("t4_pkt_beats",    pkt_beats, 3);
        check_val("t4_pkt_par",      pkt_par,   0);
        check_val("t4_pkt_err",      pkt_err,   0);
        check_val("t4_err_count",    err_count, 1);

        // Back-to-back packets: 2-beat with a checked error, then clean 1-beat.
        drive(64'hFF00, 1'b0, 1'b1, 8'h02);
        @(negedge clk);
        check_val("t5_a1_m_err",     m_err,     1);
        check_val("t5_a1_pkt_valid", pkt_valid, 0);
        drive(64'h1, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        check_val("t5_a_pkt_valid",  pkt_valid, 1);
        check_val("t5_a_pkt_beats",  pkt_beats, 2);
        check_val("t5_a_pkt_par",    pkt_par,   1);
        check_val("t5_a_pkt_err",    pkt_err,   1);
        check_val("t5_a_err_count",  err_count, 2);
        drive(64'h3, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        check_val("t5_b_pkt_valid",  pkt_valid, 1);
        check_val("t5_b_pkt_beats",  pkt_beats, 1);
        check_val("t5_b_pkt_par",    pkt_par,   0);
        check_val("t5_b_pkt_err",    pkt_err,   0);
        idle();
        @(negedge clk);

        // Reset mid-packet: partial packet discarded, asynchronous clear.
        drive(64'h5, 1'b0, 1'b0, 8'h00);
        @(negedge clk);
        check_val("t1_pre_m_valid", m_valid, 1);
        idle();
        rst_n = 1'b0;
        #1;
        check_all_zero("t1_async");
        @(negedge clk);
        rst_n = 1'b1;
        drive(64'h1, 1'b1, 1'b0, 8'h00);
        @(negedge clk);
        check_val("t1_pkt_valid", pkt_valid, 1);
        check_val("t1_pkt_beats", pkt_beats, 1);
        check_val("t1_pkt_par",   pkt_par,   1);
        idle();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
